// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath width, FSM
// encodings and the {instruction, PC} packet carried to decode.
package fetch_unit_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    FU_BUSY = 1'b0,
    FU_SKID = 1'b1
  } fu_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [DATA_W-1:0] pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: req/ack fetch from instruction memory, registered
// IF/ID output with a one-entry skid buffer, PC stall and branch-flush handling.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] address,
  output logic              stall_out,
  input  logic              FLUSH,
  input  logic              STALL_IN,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] inst_out,
  output logic [DATA_W-1:0] pc_out,
  output logic              valid_out
);

  fu_state_e         r_state,    w_state_nxt;
  logic [DATA_W-1:0] r_req_addr, w_req_addr_nxt;
  fetch_pkt_t        r_skid,     w_skid_nxt;
  fetch_pkt_t        r_out,      w_out_nxt;
  logic              r_drop,     w_drop_nxt;
  logic              r_valid,    w_valid_nxt;

  fetch_pkt_t        w_fetched;
  logic              w_ack_busy;
  logic              w_out_free;

  assign w_fetched  = {imem_rdata, r_req_addr};
  assign w_ack_busy = (r_state == FU_BUSY) && imem_ack;
  assign w_out_free = !r_valid || !STALL_IN;

  // The PC only advances on an ack that delivers a right-path instruction;
  // a flush always lets it load the branch target.
  assign stall_out = !FLUSH && ((r_state == FU_SKID) || r_drop || !imem_ack);

  assign imem_req  = (r_state == FU_BUSY);
  assign imem_addr = r_req_addr;
  assign inst_out  = r_out.inst;
  assign pc_out    = r_out.pc;
  assign valid_out = r_valid;

  // NOTE: every next-state value gets its hold default first, so no path
  // through the priority chain below can leave a latch behind.
  always_comb begin
    w_state_nxt    = r_state;
    w_req_addr_nxt = r_req_addr;
    w_skid_nxt     = r_skid;
    w_out_nxt      = r_out;
    w_drop_nxt     = r_drop;
    w_valid_nxt    = r_valid;

    if (FLUSH) begin
      w_valid_nxt = 1'b0;
      w_skid_nxt  = '0;
      w_state_nxt = FU_BUSY;
      if ((r_state == FU_BUSY) && !imem_ack) begin
        w_drop_nxt = 1'b1;
      end else begin
        // An ack here retires any outstanding wrong-path request as well.
        w_req_addr_nxt = address;
        w_drop_nxt     = 1'b0;
      end
    end else if (r_drop && w_ack_busy) begin
      w_drop_nxt     = 1'b0;
      w_req_addr_nxt = address;
    end else if (w_ack_busy) begin
      if (w_out_free) begin
        w_out_nxt   = w_fetched;
        w_valid_nxt = 1'b1;
      end else begin
        w_skid_nxt  = w_fetched;
        w_state_nxt = FU_SKID;
      end
      w_req_addr_nxt = address;
    end else if ((r_state == FU_SKID) && !STALL_IN) begin
      w_out_nxt   = r_skid;
      w_valid_nxt = 1'b1;
      w_state_nxt = FU_BUSY;
    end else if (!STALL_IN) begin
      w_valid_nxt = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= FU_BUSY;
      r_req_addr <= '0;
      r_skid     <= '0;
      r_out      <= '0;
      r_drop     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_skid     <= w_skid_nxt;
      r_out      <= w_out_nxt;
      r_drop     <= w_drop_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC and wait-state memory models, an
// in-order delivery scoreboard, directed scenarios and a randomized soak.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] address = '0;
  logic              stall_out;
  logic              flush = 1'b0;
  logic              stall_in = 1'b0;
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [DATA_W-1:0] imem_rdata = '0;
  logic [DATA_W-1:0] inst_out;
  logic [DATA_W-1:0] pc_out;
  logic              valid_out;

  int checks = 0;
  int failures = 0;

  int                wait_cfg = 0;   // fixed wait states, or -1 for random 0..3
  int                wait_left = 0;
  logic              noise = 1'b0;   // random ack while no request is pending
  logic              acc_q = 1'b0;
  logic [DATA_W-1:0] flush_tgt = '0;
  logic [DATA_W-1:0] exp_pc = '0;
  logic              pend_q = 1'b0;
  logic [DATA_W-1:0] pend_addr = '0;
  int                stall_cnt = 0;
  int                adv_cnt = 0;
  int                n_consumed = 0;
  logic [DATA_W-1:0] log_q[$];

  fetch_unit dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .address    (address),
    .stall_out  (stall_out),
    .FLUSH      (flush),
    .STALL_IN   (stall_in),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_out   (inst_out),
    .pc_out     (pc_out),
    .valid_out  (valid_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DATA_W-1:0] mem_f(input logic [DATA_W-1:0] a);
    return a + 16'h1000;
  endfunction

  function automatic int pick_wait();
    return (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
  endfunction

  function automatic int count_pc(input logic [DATA_W-1:0] a);
    int n = 0;
    foreach (log_q[i]) if (log_q[i] == a) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responds to the registered request after the configured waits.
  task automatic mem_drive();
    if (acc_q) wait_left = pick_wait();
    acc_q = 1'b0;
    if (imem_req && wait_left == 0) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_f(imem_addr);
    end else begin
      imem_ack   = imem_req ? 1'b0 : (noise & 1'($urandom_range(0, 1)));
      imem_rdata = DATA_W'($urandom);
      if (imem_req) wait_left--;
    end
  endtask

  // Falling edge: PC update, decode-side scoreboard and protocol checks.
  task automatic negedge_work();
    if (flush)
      check("stall_on_flush", DATA_W'(stall_out), DATA_W'(0));
    else if (!imem_req || !imem_ack)
      check("stall_no_ack", DATA_W'(stall_out), DATA_W'(1));
    if (pend_q && imem_req) check("addr_hold", imem_addr, pend_addr);
    pend_q    = imem_req && !imem_ack && !flush;
    pend_addr = imem_addr;

    if (flush) begin
      exp_pc = flush_tgt;
    end else if (valid_out && !stall_in) begin
      check("sb_pc", pc_out, exp_pc);
      check("sb_inst", inst_out, mem_f(exp_pc));
      log_q.push_back(pc_out);
      n_consumed++;
      exp_pc = exp_pc + 1'b1;
    end

    acc_q = imem_req && imem_ack;
    if (stall_out) stall_cnt++;
    else begin
      adv_cnt++;
      address = flush ? flush_tgt : address + 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    negedge_work();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  // Entered and left at rising edge + 1; reset is asserted mid-cycle.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_req", DATA_W'(imem_req), DATA_W'(1));
    check("rst_addr", imem_addr, '0);
    check("rst_valid", DATA_W'(valid_out), DATA_W'(0));
    check("rst_pc", pc_out, '0);
    check("rst_inst", inst_out, '0);
    address = '0; exp_pc = '0; pend_q = 1'b0; acc_q = 1'b0;
    flush = 1'b0; stall_in = 1'b0; imem_ack = 1'b0;
    wait_left = pick_wait();
    log_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rel_req", DATA_W'(imem_req), DATA_W'(1));
    check("rel_addr", imem_addr, '0);
    stall_cnt = 0; adv_cnt = 0;
    mem_drive();
  endtask

  task automatic run_until_addr(input logic [DATA_W-1:0] a, input string tag);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < 200) begin
      cycle();
      n++;
    end
    check(tag, imem_addr, a);
  endtask

  task automatic run_until_log(input int need, input string tag);
    int n = 0;
    while (log_q.size() < need && n < 200) begin
      cycle();
      n++;
    end
    check(tag, DATA_W'(log_q.size() >= need), DATA_W'(1));
  endtask

  initial begin
    int base;
    @(posedge clk);
    #1;

    // Zero-wait memory: one fetch per cycle, output one edge after each ack.
    wait_cfg = 0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      check("t1_addr", imem_addr, DATA_W'(i));
      cycle();
      check("t1_valid", DATA_W'(valid_out), DATA_W'(1));
      check("t1_pc", pc_out, DATA_W'(i));
      check("t1_inst", inst_out, DATA_W'(16'h1000 + i));
    end
    check("t1_no_stall", DATA_W'(stall_cnt), DATA_W'(0));

    // Three wait states per fetch.
    wait_cfg = 3;
    apply_reset();
    repeat (12) cycle();
    check("t2_stalls", DATA_W'(stall_cnt), DATA_W'(9));
    check("t2_advances", DATA_W'(adv_cnt), DATA_W'(3));
    run_until_log(3, "t2_delivered");
    check("t2_seq0", log_q[0], DATA_W'(0));
    check("t2_seq2", log_q[2], DATA_W'(2));

    // Decode stall while the fetch at 5 acks: inst@5 waits in the skid.
    wait_cfg = 0;
    apply_reset();
    run_until_addr(DATA_W'(5), "t3_reach");
    check("t3_pre_pc", pc_out, DATA_W'(4));
    stall_in = 1'b1;
    cycle();
    check("t3_skid_req", DATA_W'(imem_req), DATA_W'(0));
    check("t3_hold_pc", pc_out, DATA_W'(4));
    repeat (3) begin
      cycle();
      check("t3_skid_hold", DATA_W'(imem_req), DATA_W'(0));
    end
    stall_in = 1'b0;
    cycle();
    check("t3_out5", pc_out, DATA_W'(5));
    check("t3_req_back", DATA_W'(imem_req), DATA_W'(1));
    check("t3_next_addr", imem_addr, DATA_W'(6));
    repeat (3) cycle();
    check("t3_once4", DATA_W'(count_pc(DATA_W'(4))), DATA_W'(1));
    check("t3_once5", DATA_W'(count_pc(DATA_W'(5))), DATA_W'(1));

    // Flush during a pending request: its data is dropped.
    wait_cfg = 2;
    apply_reset();
    run_until_addr(DATA_W'(7), "t4_reach");
    flush = 1'b1; flush_tgt = 16'h0040;
    cycle();
    flush = 1'b0;
    check("t4_valid_clr", DATA_W'(valid_out), DATA_W'(0));
    base = 0;
    while (!imem_ack && base < 20) begin
      cycle();
      base++;
    end
    #1;
    check("t4_drop_stall", DATA_W'(stall_out), DATA_W'(1));
    check("t4_drop_addr", imem_addr, DATA_W'(7));
    cycle();
    check("t4_tgt_addr", imem_addr, 16'h0040);
    base = 0;
    while (!valid_out && base < 20) begin
      cycle();
      base++;
    end
    check("t4_first_pc", pc_out, 16'h0040);
    check("t4_first_inst", inst_out, 16'h1040);

    // Flush together with an ack.
    wait_cfg = 0;
    apply_reset();
    run_until_addr(DATA_W'(3), "t5_reach");
    flush = 1'b1; flush_tgt = 16'h0080;
    cycle();
    flush = 1'b0;
    check("t5_valid_clr", DATA_W'(valid_out), DATA_W'(0));
    check("t5_tgt_addr", imem_addr, 16'h0080);
    cycle();
    check("t5_first_pc", pc_out, 16'h0080);

    // Flush while the skid buffer is full.
    run_until_addr(16'h0085, "t5b_reach");
    stall_in = 1'b1;
    cycle();
    check("t5b_skid", DATA_W'(imem_req), DATA_W'(0));
    flush = 1'b1; flush_tgt = 16'h0200;
    cycle();
    flush = 1'b0; stall_in = 1'b0;
    check("t5b_valid_clr", DATA_W'(valid_out), DATA_W'(0));
    check("t5b_req", DATA_W'(imem_req), DATA_W'(1));
    check("t5b_tgt_addr", imem_addr, 16'h0200);
    cycle();
    check("t5b_first_pc", pc_out, 16'h0200);
    check("t5b_no85", DATA_W'(count_pc(16'h0085)), DATA_W'(0));

    // Reset asserted mid-wait at address 9.
    wait_cfg = 3;
    apply_reset();
    run_until_addr(DATA_W'(9), "t6_reach");
    check("t6_pre_pc", pc_out, DATA_W'(8));
    apply_reset();

    // Randomized soak: random waits, decode stalls, flushes incl. wrap targets.
    wait_cfg = -1;
    noise = 1'b1;
    apply_reset();
    base = n_consumed;
    for (int i = 0; i < 3000; i++) begin
      flush    = ($urandom_range(0, 15) == 0) || (flush && $urandom_range(0, 2) == 0);
      stall_in = ($urandom_range(0, 2) == 0);
      if (flush) flush_tgt = $urandom_range(0, 3) == 0 ? 16'hFFFE : DATA_W'($urandom);
      cycle();
    end
    flush = 1'b0; stall_in = 1'b0;
    repeat (10) cycle();
    check("rand_progress", DATA_W'(n_consumed - base > 300), DATA_W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage between the program counter and the decode stage. Each cycle it issues the current PC value to instruction memory over a req/ack handshake, tolerating any number of wait states. It delivers {instruction, PC} to decode through a registered IF/ID output with a one-entry skid buffer. It drives the PC's STALL input and discards wrong-path fetches on branch redirect (FLUSH, asserted together with the PC's PCSRC).

## Interface
- DATA_W, 16 (`DATA_W`), address and instruction width
- CLK  in  1  clock; this block's registers update on the rising edge, and the PC updates on the falling edge
- RST_N  in  1  reset, asynchronous, active-low
- address  in  DATA_W  current PC value from the program counter
- stall_out  out  DATA_W→1  STALL to the program counter, combinational
- FLUSH  in  1  branch redirect from execute; high in the same cycle as PCSRC
- STALL_IN  in  1  decode cannot accept a new instruction this cycle
- imem_req  out  1  fetch request
- imem_addr  out  DATA_W  fetch address, registered, stable while imem_req is high
- imem_ack  in  1  imem_rdata is valid this cycle; only meaningful while imem_req is high
- imem_rdata  in  DATA_W  fetched instruction
- inst_out  out  DATA_W  IF/ID instruction
- pc_out  out  DATA_W  address of inst_out
- valid_out  out  1  inst_out and pc_out hold a live instruction

## Operation
- State machine: BUSY (imem_req=1) and SKID (imem_req=0; the skid buffer holds one instruction).
- Registers: req_addr (drives imem_addr), skid_inst/skid_pc, drop_q (a wrong-path request is outstanding), output register.
- stall_out = !FLUSH & (state==SKID | drop_q | !imem_ack).
  - The PC therefore advances exactly on an accepted ack, and loads the branch target whenever FLUSH is high.
- Rising-edge actions, highest priority first:
  1. FLUSH:
     - valid_out<=0; skid is cleared; state<=BUSY.
     - If state==BUSY and !imem_ack: drop_q<=1. Otherwise req_addr<=address (the target).
  2. drop_q & imem_ack: discard imem_rdata; drop_q<=0; req_addr<=address.
  3. BUSY & imem_ack & !drop_q:
     - If !valid_out | !STALL_IN: output<={imem_rdata, req_addr}, valid_out<=1.
     - Otherwise: skid<={imem_rdata, req_addr}, state<=SKID.
     - In both cases req_addr<=address.
  4. SKID & !STALL_IN: output<=skid, valid_out<=1, state<=BUSY.
  5. Otherwise, if !STALL_IN then valid_out<=0 (decode consumed the output and nothing replaced it).
- Decode consumes the output at a rising edge with valid_out & !STALL_IN.
- Addresses wrap modulo 2^DATA_W; wrap needs no special handling.

## Timing
- Reset values:
  - state=BUSY, req_addr=0, drop_q=0
  - valid_out=0, inst_out=0, pc_out=0, skid=0
  - Result: imem_req=1 and imem_addr=0 immediately after reset.
- RST_N asserted mid-request abandons the request; memory must drop any pending ack on reset.
- Zero-wait memory (ack in the request cycle): one instruction per cycle.
  - Latency from imem_ack to valid_out is one rising edge.
- N wait cycles: stall_out stays high for N cycles; the PC holds.
- imem_addr changes only at a rising edge where an ack is accepted or FLUSH is applied; never while a request is pending.
- FLUSH in the same cycle as ack: data dropped; the next request goes to the target.
- FLUSH without ack: the outstanding request completes, its data is dropped, and stall_out stays high through that ack cycle.
- Back-to-back FLUSH cycles: each one reloads; only the last target is fetched.
- SKID and STALL_IN high: imem_req=0 and stall_out=1 until STALL_IN falls.

## Structure
- def.v additions:
  - FU_BUSY and FU_SKID state encodings
  - reuse `DATA_W`
- Single flat module. The skid buffer is two registers and needs no sub-module.

## Test plan
- Reset, zero-wait memory, program 0x1000,0x1001,0x1002 at 0..2 -> imem_addr 0,1,2 on consecutive cycles; valid_out=1 with pc_out 0,1,2 and inst_out 0x1000..0x1002 one cycle after each ack; stall_out never high.
- Memory with 3 wait states per fetch -> stall_out high 3 cycles per fetch; address increments only after each ack; pc_out sequence 0,1,2 with no gaps or duplicates.
- STALL_IN high for 4 cycles while the fetch at address 5 acks -> inst@5 enters skid, state=SKID, imem_req=0; after STALL_IN falls decode sees inst@4 and then inst@5, each exactly once.
- FLUSH with target 0x0040 during a pending request at address 7, ack 2 cycles later -> inst@7 never appears on valid_out; next imem_addr=0x0040; pc_out=0x0040 is the next valid output.
- FLUSH in the same cycle as an ack, and FLUSH while in SKID -> valid_out=0 next cycle, skid cleared, next request at the target.
- RST_N pulsed low mid-wait at address 9 -> all outputs return to their reset values asynchronously; after release imem_addr=0 and imem_req=1.
